// File: rtl/dw_reg_array.sv
`default_nettype none
// ============================================================================
// Module   : dw_reg_array
// Purpose  : Per-row pixel register array between the input-buffer interface
//            controller and the depthwise PE array. Each row executes a 2-bit
//            command every cycle:
//              00 IB - load from input buffer
//              01 SF - shift down from row above
//              10 IF - load from the reuse FIFO head
//              11 NE - hold
//            POY-1 reuse FIFO lanes capture overlapping rows on buffer loads.
//            Those rows are replayed on later window transitions so they do
//            not have to be re-read from the input buffer.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            cmd             - row i command in [2i+1:2i]
//            buf_vld/buf_pix - input-buffer read data (already aligned)
//            fifo_read       - pop pulse for all reuse lanes
//            dwpe_ena        - compute enable from the controller
//            pix_out         - row registers, row i at [DW*i+DW-1:DW*i]
//            pix_vld         - registered "rows updated while enabled"
//            fifo_empty/full - lane 0 status (all lanes move in lockstep)
//            fifo_ovf/unf    - sticky push-while-full / pop-while-empty
// Options  : define DW_REG_ARRAY_ERR_EN to build the sticky error flags;
//            otherwise fifo_ovf and fifo_unf are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module dw_reg_array #(
    parameter int POY        = 3,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*POY-1:0]    cmd,
    input  logic                buf_vld,
    input  logic [DW*POY-1:0]   buf_pix,
    input  logic                fifo_read,
    input  logic                dwpe_ena,
    output logic [DW*POY-1:0]   pix_out,
    output logic                pix_vld,
    output logic                fifo_empty,
    output logic                fifo_full,
    output logic                fifo_ovf,
    output logic                fifo_unf
);

    localparam logic [1:0] c_CMD_IB = 2'b00;
    localparam logic [1:0] c_CMD_SF = 2'b01;
    localparam logic [1:0] c_CMD_IF = 2'b10;
    localparam logic [1:0] c_CMD_NE = 2'b11;

    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam int c_LANES = POY - 1;
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(FIFO_DEPTH);

    logic [1:0]      w_cmd     [POY];
    logic [DW-1:0]   w_buf     [POY];
    logic [DW-1:0]   w_row_nxt [POY];
    logic [DW-1:0]   r_row     [POY];
    logic [DW-1:0]   r_fifo_q  [c_LANES];
    logic [DW-1:0]   r_mem     [c_LANES][FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_pix_vld;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_any_cmd;

    // ------------------------------------------------------------------
    // Per-row command decode and next-value selection
    // ------------------------------------------------------------------
    for (genvar i = 0; i < POY; i++) begin : g_row
        assign w_cmd[i]              = cmd[2*i +: 2];
        assign w_buf[i]              = buf_pix[DW*i +: DW];
        assign pix_out[DW*i +: DW]   = r_row[i];

        if (i < POY-1) begin : g_lower
            assign w_row_nxt[i] = (w_cmd[i] == c_CMD_SF)             ? r_row[i+1]  :
                                  (w_cmd[i] == c_CMD_IF)             ? r_fifo_q[i] :
                                  (w_cmd[i] == c_CMD_IB && buf_vld)  ? w_buf[i]    :
                                                                       r_row[i];
        end else begin : g_top
            // The top row has nothing above it to shift from and no reuse
            // lane of its own, so SF holds and IF behaves like IB.
            assign w_row_nxt[i] = ((w_cmd[i] == c_CMD_IB || w_cmd[i] == c_CMD_IF) && buf_vld)
                                  ? w_buf[i] : r_row[i];
        end
    end

    // All rows at NE means every command bit is set.
    assign w_any_cmd = ~(&cmd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < POY; i++) begin
                r_row[i] <= '0;
            end
            r_pix_vld <= 1'b0;
        end else begin
            for (int i = 0; i < POY; i++) begin
                r_row[i] <= w_row_nxt[i];
            end
            r_pix_vld <= dwpe_ena & w_any_cmd;
        end
    end

    assign pix_vld = r_pix_vld;

    // ------------------------------------------------------------------
    // Reuse FIFO lanes. The lanes share one set of pointers and one count
    // so they can never drift apart; the push decision is taken from
    // lane 0 (row 1 loading from the buffer) and applied to every lane.
    // A pop frees its slot in the same cycle, so a push into a full FIFO
    // is accepted when it coincides with a pop. When full and popping,
    // write and read pointers are equal; the read still returns the old
    // entry because both accesses are registered.
    // ------------------------------------------------------------------
    assign w_push_req = buf_vld && (w_cmd[1] == c_CMD_IB);
    assign w_pop      = fifo_read && (r_count != '0);
    assign w_push     = w_push_req && ((r_count != c_FULL_CNT) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int l = 0; l < c_LANES; l++) begin
                r_fifo_q[l] <= '0;
                for (int d = 0; d < FIFO_DEPTH; d++) begin
                    r_mem[l][d] <= '0;
                end
            end
        end else begin
            if (w_push) begin
                for (int l = 0; l < c_LANES; l++) begin
                    r_mem[l][r_wr_ptr] <= w_buf[l+1];
                end
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                for (int l = 0; l < c_LANES; l++) begin
                    r_fifo_q[l] <= r_mem[l][r_rd_ptr];
                end
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    assign fifo_empty = (r_count == '0);
    assign fifo_full  = (r_count == c_FULL_CNT);

`ifdef DW_REG_ARRAY_ERR_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (fifo_read && !w_pop) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign fifo_ovf = r_ovf;
    assign fifo_unf = r_unf;
`else
    assign fifo_ovf = 1'b0;
    assign fifo_unf = 1'b0;
`endif

endmodule
`default_nettype wire
